// File: rtl/csr_commit_queue_pkg.sv
// Shared types and helpers for the CSR commit queue: issue payload, queue entry and the
// landing-pad address remap that decode also uses.
package csr_commit_queue_pkg;

    localparam int unsigned XLEN = 64;

    // Landing-pad label register targeted by the CFI landing-pad operators.
    localparam logic [11:0] CSR_LPLR = 12'h8C0;

    typedef enum logic [3:0] {
        ADD,
        CSRRW,
        CSRRS,
        CSRRC,
        LPSLL,
        LPSML,
        LPSUL,
        LPCLL
    } fu_op;

    typedef struct packed {
        fu_op            operator;
        logic [XLEN-1:0] operand_a;
        logic [XLEN-1:0] operand_b;
    } fu_data_t;

    typedef struct packed {
        logic [11:0] csr_address;
    } csr_q_entry_t;

    function automatic logic [11:0] cfi_csr_addr(fu_op op, logic [11:0] raw, logic en);
        logic w_is_lp;
        w_is_lp = (op == LPSLL) || (op == LPSML) || (op == LPSUL) || (op == LPCLL);
        return (en && w_is_lp) ? CSR_LPLR : raw;
    endfunction

endpackage

// File: rtl/csr_commit_queue.sv
// Circular queue of pending CSR addresses between issue and commit, with a combinational
// ready bypass so a full queue can accept while its head retires.
module csr_commit_queue
    import csr_commit_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter bit          CFI_REMAP_EN = 1'b1,
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  fu_data_t         fu_data_i,
    input  logic             csr_valid_i,
    output logic             csr_ready_o,
    output logic [XLEN-1:0]  csr_result_o,
    input  logic             csr_commit_i,
    output logic [11:0]      csr_addr_o,
    output logic             csr_addr_valid_o,
    output logic [CNT_W-1:0] count_o,
    output logic             commit_err_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    csr_q_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_commit_err;

    logic [PTR_W-1:0] w_rd_ptr_d;
    logic [PTR_W-1:0] w_wr_ptr_d;
    logic [CNT_W-1:0] w_count_d;
    logic             w_commit_err_d;
    logic             w_not_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    csr_q_entry_t     w_entry;
    logic             w_unused_operand_b;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_unused_operand_b = ^fu_data_i.operand_b[XLEN-1:12];

    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));

    assign csr_ready_o = !w_full || (csr_commit_i && w_not_empty);
    assign w_push      = csr_valid_i && csr_ready_o && !flush_i;
    assign w_pop       = csr_commit_i && w_not_empty && !flush_i;

    assign w_entry.csr_address = cfi_csr_addr(fu_data_i.operator, fu_data_i.operand_b[11:0],
                                              CFI_REMAP_EN);

    always_comb begin
        w_rd_ptr_d     = r_rd_ptr;
        w_wr_ptr_d     = r_wr_ptr;
        w_count_d      = r_count;
        w_commit_err_d = 1'b0;
        if (flush_i) begin
            w_rd_ptr_d = '0;
            w_wr_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_d = ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                w_rd_ptr_d = ptr_inc(r_rd_ptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   w_count_d = r_count + CNT_W'(1);
                2'b01:   w_count_d = r_count - CNT_W'(1);
                default: w_count_d = r_count;
            endcase
            w_commit_err_d = csr_commit_i && !w_not_empty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_commit_err <= 1'b0;
        end else begin
            r_rd_ptr     <= w_rd_ptr_d;
            r_wr_ptr     <= w_wr_ptr_d;
            r_count      <= w_count_d;
            r_commit_err <= w_commit_err_d;
        end
    end

    // Storage needs no reset: validity is tracked by the count alone.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign csr_result_o     = fu_data_i.operand_a;
    assign csr_addr_o       = w_not_empty ? r_mem[r_rd_ptr].csr_address : 12'h000;
    assign csr_addr_valid_o = w_not_empty;
    assign count_o          = r_count;
    assign commit_err_o     = r_commit_err;

    a_no_drop: assert property (@(posedge clk_i) disable iff (!rst_ni)
        csr_valid_i |-> csr_ready_o);

    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_csr_commit_queue.sv
// Scoreboard bench: driver queues expected head addresses, a monitor checks each retirement.
module tb_csr_commit_queue;
    import csr_commit_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  valid, commit, flush, ready, addr_v, err;
    fu_data_t    fu [3];
    logic [63:0] res [3];
    logic [11:0] addr [3];
    logic [1:0]  cnt [3];

    typedef struct {
        int          id;
        logic [11:0] addr;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0;
    int n_total = 0;

    fu_op        t_op [6];
    logic [63:0] t_b [6];
    logic [11:0] t_e0 [6];
    logic [11:0] t_e1 [6];

    always #5 clk = ~clk;

    csr_commit_queue #(.DEPTH(2), .CFI_REMAP_EN(1'b1)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .fu_data_i(fu[0]),
        .csr_valid_i(valid[0]), .csr_ready_o(ready[0]), .csr_result_o(res[0]),
        .csr_commit_i(commit[0]), .csr_addr_o(addr[0]), .csr_addr_valid_o(addr_v[0]),
        .count_o(cnt[0]), .commit_err_o(err[0]));

    csr_commit_queue #(.DEPTH(2), .CFI_REMAP_EN(1'b0)) u_d2n (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .fu_data_i(fu[1]),
        .csr_valid_i(valid[1]), .csr_ready_o(ready[1]), .csr_result_o(res[1]),
        .csr_commit_i(commit[1]), .csr_addr_o(addr[1]), .csr_addr_valid_o(addr_v[1]),
        .count_o(cnt[1]), .commit_err_o(err[1]));

    csr_commit_queue #(.DEPTH(3), .CFI_REMAP_EN(1'b1)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]), .fu_data_i(fu[2]),
        .csr_valid_i(valid[2]), .csr_ready_o(ready[2]), .csr_result_o(res[2]),
        .csr_commit_i(commit[2]), .csr_addr_o(addr[2]), .csr_addr_valid_o(addr_v[2]),
        .count_o(cnt[2]), .commit_err_o(err[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input int d, input logic v, input fu_op op, input logic [63:0] b,
                         input logic [11:0] exp_addr, input logic c, input logic f);
        valid[d]           = v;
        commit[d]          = c;
        flush[d]           = f;
        fu[d].operator     = op;
        fu[d].operand_b    = b;
        if (v && !f && rst_n) exp_q.push_back('{id: d, addr: exp_addr});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        valid  = '0;
        commit = '0;
        flush  = '0;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Monitor: every retirement presented by a DUT must match the oldest expected entry.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && commit[i] && !flush[i] && addr_v[i]) begin
                if (exp_q.size() == 0) begin
                    chk("retire_unexpected", 64'(i), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("retire_dut", 64'(i), 64'(e.id));
                    chk("retire_addr", 64'(addr[i]), 64'(e.addr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        t_op = '{LPSUL, LPCLL, LPSML, LPSLL, CSRRS, CSRRC};
        t_b  = '{64'h123, 64'h7FF, 64'h5A5, 64'h001, 64'h12F00, 64'h7C0};
        t_e0 = '{CSR_LPLR, CSR_LPLR, CSR_LPLR, CSR_LPLR, 12'hF00, 12'h7C0};
        t_e1 = '{12'h123, 12'h7FF, 12'h5A5, 12'h001, 12'hF00, 12'h7C0};
        rst_n = 1'b0;
        valid = '0; commit = '0; flush = '0;
        for (int i = 0; i < 3; i++) fu[i] = '{operator: ADD, operand_a: '0, operand_b: '0};
        nxt();
        nxt();
        rst_n = 1'b1;
        neg();
        for (int i = 0; i < 3; i++) begin
            chk("rst_addr", 64'(addr[i]), 64'h0);
            chk("rst_addr_valid", 64'(addr_v[i]), 64'h0);
            chk("rst_ready", 64'(ready[i]), 64'h1);
            chk("rst_count", 64'(cnt[i]), 64'h0);
            chk("rst_err", 64'(err[i]), 64'h0);
        end

        // Fill DEPTH=2 queue.
        nxt(); drive(0, 1, CSRRW, 64'h300, 12'h300, 0, 0);
        neg(); chk("fill0_count", 64'(cnt[0]), 64'h0); chk("fill0_valid", 64'(addr_v[0]), 64'h0);
        nxt(); drive(0, 1, CSRRW, 64'h341, 12'h341, 0, 0);
        neg(); chk("fill1_count", 64'(cnt[0]), 64'h1); chk("fill1_addr", 64'(addr[0]), 64'h300);
        nxt();
        neg(); chk("full_count", 64'(cnt[0]), 64'h2); chk("full_ready", 64'(ready[0]), 64'h0);
        chk("full_addr", 64'(addr[0]), 64'h300); chk("full_valid", 64'(addr_v[0]), 64'h1);

        // Push and commit together at full.
        nxt(); drive(0, 1, CSRRW, 64'h305, 12'h305, 1, 0);
        neg(); chk("bypass_ready", 64'(ready[0]), 64'h1); chk("bypass_count", 64'(cnt[0]), 64'h2);
        nxt();
        neg(); chk("after_bypass_count", 64'(cnt[0]), 64'h2);
        chk("after_bypass_addr", 64'(addr[0]), 64'h341);
        nxt(); drive(0, 0, ADD, 64'h0, 12'h0, 1, 0);
        nxt(); drive(0, 0, ADD, 64'h0, 12'h0, 1, 0);
        neg(); chk("drain_count", 64'(cnt[0]), 64'h1); chk("drain_addr", 64'(addr[0]), 64'h305);
        nxt();
        neg(); chk("empty_count", 64'(cnt[0]), 64'h0); chk("empty_addr", 64'(addr[0]), 64'h0);
        chk("empty_valid", 64'(addr_v[0]), 64'h0); chk("empty_err", 64'(err[0]), 64'h0);

        // Landing-pad remap, with (DUT0) and without (DUT1) CFI_REMAP_EN.
        for (int k = 0; k < 6; k++) begin
            nxt();
            fu[0].operand_a = 64'hDEAD_0000_0000_0000 | 64'(k);
            drive(0, 1, t_op[k], t_b[k], t_e0[k], k > 0, 0);
            drive(1, 1, t_op[k], t_b[k], t_e1[k], k > 0, 0);
            neg();
            chk("result_passthru", res[0], 64'hDEAD_0000_0000_0000 | 64'(k));
            if (k > 0) chk("remap_count", 64'(cnt[0]), 64'h1);
        end
        nxt(); drive(0, 0, ADD, 64'h0, 12'h0, 1, 0); drive(1, 0, ADD, 64'h0, 12'h0, 1, 0);
        nxt();
        neg(); chk("remap_drain0", 64'(cnt[0]), 64'h0); chk("remap_drain1", 64'(cnt[1]), 64'h0);

        // Spurious commit: registered one-cycle pulse, suppressed by flush.
        nxt(); drive(0, 0, ADD, 64'h0, 12'h0, 1, 0);
        neg(); chk("spur_err_same", 64'(err[0]), 64'h0);
        nxt();
        neg(); chk("spur_err_pulse", 64'(err[0]), 64'h1); chk("spur_count", 64'(cnt[0]), 64'h0);
        nxt();
        neg(); chk("spur_err_clear", 64'(err[0]), 64'h0);
        nxt(); drive(0, 0, ADD, 64'h0, 12'h0, 1, 1);
        nxt();
        neg(); chk("spur_flush_err", 64'(err[0]), 64'h0);
        nxt(); drive(0, 1, CSRRW, 64'h111, 12'h111, 0, 0);
        nxt(); drive(0, 0, ADD, 64'h0, 12'h0, 1, 0);
        neg(); chk("spur_next_addr", 64'(addr[0]), 64'h111);
        nxt();

        // Flush with two pending entries and a same-cycle push (DEPTH=3).
        nxt(); drive(2, 1, CSRRW, 64'h211, 12'h211, 0, 0);
        nxt(); drive(2, 1, CSRRW, 64'h222, 12'h222, 0, 0);
        nxt();
        neg(); chk("pre_flush_count", 64'(cnt[2]), 64'h2);
        nxt(); drive(2, 1, CSRRW, 64'h333, 12'h333, 0, 1);
        exp_q.delete();
        nxt();
        neg(); chk("flush_count", 64'(cnt[2]), 64'h0); chk("flush_valid", 64'(addr_v[2]), 64'h0);
        chk("flush_addr", 64'(addr[2]), 64'h0);
        nxt(); drive(2, 1, CSRRW, 64'h444, 12'h444, 0, 0);
        nxt(); drive(2, 0, ADD, 64'h0, 12'h0, 1, 0);
        neg(); chk("post_flush_addr", 64'(addr[2]), 64'h444);

        // DEPTH=3 pointer wrap with steady push/pop, then reset mid-stream.
        nxt(); drive(2, 1, CSRRW, 64'h3A0, 12'h3A0, 0, 0);
        nxt(); drive(2, 1, CSRRW, 64'h3A1, 12'h3A1, 0, 0);
        for (int k = 2; k < 9; k++) begin
            nxt(); drive(2, 1, CSRRW, 64'h3A0 + 64'(k), 12'h3A0 + 12'(k), 1, 0);
            neg(); chk("wrap_count", 64'(cnt[2]), 64'h2);
        end
        nxt(); drive(2, 0, ADD, 64'h0, 12'h0, 1, 0);
        nxt();
        neg(); chk("pre_rst_count", 64'(cnt[2]), 64'h1); chk("pre_rst_addr", 64'(addr[2]), 64'h3A8);
        rst_n = 1'b0;
        drive(2, 1, CSRRW, 64'h3B0, 12'h3B0, 0, 0);
        exp_q.delete();
        nxt();
        rst_n = 1'b1;
        neg();
        chk("mid_rst_count", 64'(cnt[2]), 64'h0); chk("mid_rst_valid", 64'(addr_v[2]), 64'h0);
        chk("mid_rst_addr", 64'(addr[2]), 64'h0); chk("mid_rst_ready", 64'(ready[2]), 64'h1);
        chk("mid_rst_err", 64'(err[2]), 64'h0);
        nxt(); drive(2, 1, CSRRW, 64'h3C0, 12'h3C0, 0, 0);
        nxt(); drive(2, 0, ADD, 64'h0, 12'h0, 1, 0);
        neg(); chk("post_rst_addr", 64'(addr[2]), 64'h3C0);
        nxt();
        nxt();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
